// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: word width, round-constant table, small sigma
// functions and the message-schedule state encoding.
package sha_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha_k_rom.sv
// Combinational SHA-256 round-constant lookup, shared by the schedule and
// any other stage that needs K_t.
module sha_k_rom
  import sha_pkg::*;
(
  input  logic [5:0]        idx_i,
  output logic [WORD_W-1:0] k_o
);

  assign k_o = K[idx_i];

endmodule

// File: rtl/sha_message_schedule.sv
// SHA-256 message schedule: captures one 512-bit block and streams (W_t, K_t)
// for t = 0..63 through a 16-word sliding window, one round per handshake.
module sha_message_schedule
  import sha_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [511:0]              block_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         Wt,
  output logic [WORD_W-1:0]         Kt,
  output logic [$clog2(ROUNDS)-1:0] round,
  output logic                      last
);

  localparam int RW = $clog2(ROUNDS);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  sched_state_e      state_q, state_d;
  logic [RW-1:0]     round_q, round_d;
  logic [WORD_W-1:0] w_q [16];
  logic [WORD_W-1:0] w_d [16];
  logic [WORD_W-1:0] wNew;

  // Words pushed in after round 47 are never emitted; computing them anyway keeps the datapath uniform.
  assign wNew = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    w_d     = w_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < 16; i++) begin
            w_d[i] = block_in[511 - 32*i -: 32];
          end
          round_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          for (int i = 0; i < 15; i++) begin
            w_d[i] = w_q[i+1];
          end
          w_d[15] = wNew;
          round_d = round_q + 1'b1;
          if (round_q == LAST_ROUND) begin
            round_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      round_q <= '0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      w_q     <= w_d;
    end
  end

  sha_k_rom u_k_rom (
    .idx_i (round_q),
    .k_o   (Kt)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RUN);
  assign Wt        = w_q[0];
  assign round     = round_q;
  assign last      = (state_q == RUN) && (round_q == LAST_ROUND);

endmodule
